// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO bus-access sequencer: state encoding,
// slot numbers and the default slot population / handshake masks.
package mmio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } mmio_state_t;

   localparam logic [3:0] SLOT_BASIC_IO = 4'd0;
   localparam logic [3:0] SLOT_KEYPAD   = 4'd1;
   localparam logic [3:0] SLOT_SOUND    = 4'd2;
   localparam logic [3:0] SLOT_VGATERM  = 4'd3;
   localparam logic [3:0] SLOT_PS2      = 4'd4;
   localparam logic [3:0] SLOT_SD       = 4'd5;

   function automatic logic [15:0] slot_onehot(input logic [3:0] slot);
      return 16'h0001 << slot;
   endfunction

   localparam logic [15:0] PRESENT_DEFAULT =
      slot_onehot(SLOT_BASIC_IO) | slot_onehot(SLOT_KEYPAD) | slot_onehot(SLOT_SOUND) |
      slot_onehot(SLOT_VGATERM)  | slot_onehot(SLOT_PS2)    | slot_onehot(SLOT_SD);

   localparam logic [15:0] HS_MASK_DEFAULT =
      slot_onehot(SLOT_VGATERM) | slot_onehot(SLOT_PS2) | slot_onehot(SLOT_SD);

endpackage

// File: rtl/mmio_watchdog.sv
// Handshake watchdog: counts WAIT cycles of a handshake access and keeps a
// sticky record of the first slot that timed out.
module mmio_watchdog #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic       system_clk,
   input  logic       rst_n,
   input  logic       cnt_clr,
   input  logic       in_wait,
   input  logic       ack_ok,
   input  logic [3:0] slot,
   input  logic       err_clr,
   output logic       expired,
   output logic       err_valid,
   output logic [3:0] err_slot
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_inc;

   assign cnt_inc = cnt_q + 8'd1;
   // An ack arriving in the final WAIT cycle still wins over the abort.
   assign expired = in_wait & ~ack_ok & (cnt_inc == TIMEOUT);

   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else if (cnt_clr) begin
         cnt_q <= 8'd0;
      end else if (in_wait) begin
         cnt_q <= cnt_inc;
      end
   end

   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         err_valid <= 1'b0;
         err_slot  <= 4'd0;
      end else if (err_clr) begin
         err_valid <= 1'b0;
      end else if (expired && !err_valid) begin
         err_valid <= 1'b1;
         err_slot  <= slot;
      end
   end

endmodule

// File: rtl/mmio_access_ctrl.sv
// Sequences CPU I/O-window accesses onto 16 peripheral slots, stalling the CPU
// until a legacy turnaround or a handshake ack (or watchdog abort) completes.
//
// state | meaning
// IDLE  | no access; a request latches slot/reg/data/op
// ISSUE | one-cycle select plus read or write strobe
// WAIT  | legacy: single sample cycle; handshake: hold select until ack/timeout
// DONE  | release cpu_wait for one cycle, select dropped
module mmio_access_ctrl
   import mmio_pkg::*;
#(
   parameter logic [15:0] PRESENT = PRESENT_DEFAULT,
   parameter logic [15:0] HS_MASK = HS_MASK_DEFAULT,
   parameter logic [7:0]  TIMEOUT = 8'd255
) (
   input  logic          system_clk,
   input  logic          rst_n,
   input  logic          cpu_re,
   input  logic          cpu_we,
   input  logic [11:0]   cpu_addr,
   input  logic [7:0]    cpu_wdata,
   output logic [7:0]    cpu_rdata,
   output logic          cpu_wait,
   output logic [15:0]   per_sel,
   output logic          per_re,
   output logic          per_we,
   output logic [7:0]    per_addr,
   output logic [7:0]    per_wdata,
   input  logic [127:0]  per_rdata,
   input  logic [15:0]   per_stall,
   input  logic [15:0]   per_ack,
   output logic          err_valid,
   output logic [3:0]    err_slot,
   input  logic          err_clr
);

   mmio_state_t state_q, state_d;
   logic [3:0]  slot_q;
   logic [7:0]  addr_q;
   logic [7:0]  wdata_q;
   logic [7:0]  rdata_q;
   logic        write_q;

   logic        req;
   logic        slot_hs;
   logic        ack_ok;
   logic        expired;
   logic        in_wait_hs;
   logic [7:0]  slot_rdata;

   assign req        = cpu_re | cpu_we;
   assign slot_hs    = HS_MASK[slot_q];
   assign ack_ok     = per_ack[slot_q] & ~per_stall[slot_q];
   assign slot_rdata = per_rdata[{slot_q, 3'b000} +: 8];
   assign in_wait_hs = (state_q == ST_WAIT) & slot_hs;

   mmio_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .system_clk (system_clk),
      .rst_n      (rst_n),
      .cnt_clr    (state_q == ST_ISSUE),
      .in_wait    (in_wait_hs),
      .ack_ok     (ack_ok),
      .slot       (slot_q),
      .err_clr    (err_clr),
      .expired    (expired),
      .err_valid  (err_valid),
      .err_slot   (err_slot)
   );

   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               state_d = PRESENT[cpu_addr[11:8]] ? ST_ISSUE : ST_DONE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (!slot_hs || ack_ok || expired) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Write wins when both request lines are high.
   always_ff @(posedge system_clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q  <= 4'd0;
         addr_q  <= 8'd0;
         wdata_q <= 8'd0;
         write_q <= 1'b0;
         rdata_q <= 8'd0;
      end else begin
         if (state_q == ST_IDLE && req) begin
            slot_q  <= cpu_addr[11:8];
            addr_q  <= cpu_addr[7:0];
            wdata_q <= cpu_wdata;
            write_q <= cpu_we;
            if (!PRESENT[cpu_addr[11:8]] && !cpu_we) begin
               rdata_q <= 8'h00;
            end
         end
         if (state_q == ST_WAIT && !write_q) begin
            if (!slot_hs || ack_ok) begin
               rdata_q <= slot_rdata;
            end else if (expired) begin
               rdata_q <= 8'hFF;
            end
         end
      end
   end

   always_comb begin
      cpu_wait = 1'b0;
      per_sel  = 16'h0000;
      per_re   = 1'b0;
      per_we   = 1'b0;
      case (state_q)
         ST_IDLE: cpu_wait = req;
         ST_ISSUE: begin
            cpu_wait = 1'b1;
            per_sel  = slot_onehot(slot_q);
            per_re   = ~write_q;
            per_we   = write_q;
         end
         ST_WAIT: begin
            cpu_wait = 1'b1;
            per_sel  = slot_onehot(slot_q);
         end
         default: ;
      endcase
   end

   assign per_addr  = addr_q;
   assign per_wdata = wdata_q;
   assign cpu_rdata = rdata_q;

endmodule

// File: tb/tb_mmio_access_ctrl.sv
// Self-checking bench for mmio_access_ctrl: directed vector table, hand-built
// error/reset sequences, then randomized accesses against a timing model.
module tb_mmio_access_ctrl;

   localparam int          TO      = 8;
   localparam logic [15:0] PRES_M  = 16'h003F;
   localparam logic [15:0] HS_M    = 16'h0038;

   logic          system_clk;
   logic          rst_n;
   logic          cpu_re, cpu_we;
   logic [11:0]   cpu_addr;
   logic [7:0]    cpu_wdata;
   logic [7:0]    cpu_rdata;
   logic          cpu_wait;
   logic [15:0]   per_sel;
   logic          per_re, per_we;
   logic [7:0]    per_addr, per_wdata;
   logic [127:0]  per_rdata;
   logic [15:0]   per_stall, per_ack;
   logic          err_valid;
   logic [3:0]    err_slot;
   logic          err_clr;

   int errors = 0;
   int checks = 0;

   mmio_access_ctrl #(.TIMEOUT(8'(TO))) dut (
      .system_clk (system_clk),
      .rst_n      (rst_n),
      .cpu_re     (cpu_re),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_wait   (cpu_wait),
      .per_sel    (per_sel),
      .per_re     (per_re),
      .per_we     (per_we),
      .per_addr   (per_addr),
      .per_wdata  (per_wdata),
      .per_rdata  (per_rdata),
      .per_stall  (per_stall),
      .per_ack    (per_ack),
      .err_valid  (err_valid),
      .err_slot   (err_slot),
      .err_clr    (err_clr)
   );

   initial system_clk = 1'b0;
   always #5 system_clk = ~system_clk;

   typedef struct {
      logic        we;
      logic        re;
      logic [11:0] addr;
      logic [7:0]  wdata;
      int          ack_at;
      int          stall_until;
      int          exp_waits;
      int          exp_sel_cyc;
      logic [15:0] exp_sel;
      int          exp_re;
      int          exp_we;
      logic [7:0]  exp_rdata;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge system_clk);
      #1;
   endtask

   task automatic set_slot(input int n, input logic [7:0] v);
      per_rdata[8*n +: 8] = v;
   endtask

   // Called at posedge+1 of the request cycle T0. WAIT cycle k is cycle T(k+1).
   task automatic run_access(input logic we, input logic re, input logic [11:0] addr,
                             input logic [7:0] wdata, input int ack_at, input int stall_until,
                             output int waits, output int sel_cyc, output logic [15:0] sel_or,
                             output int re_n, output int we_n, output logic [7:0] s_addr,
                             output logic [7:0] s_wdata, output logic [7:0] rd);
      logic [15:0] tmask;
      logic [31:0] noise;
      bit          done;
      waits = 0; sel_cyc = 0; sel_or = '0; re_n = 0; we_n = 0;
      s_addr = '0; s_wdata = '0; rd = '0; done = 0;
      tmask = 16'h0001 << addr[11:8];
      cpu_addr = addr; cpu_wdata = wdata; cpu_re = re; cpu_we = we;
      for (int n = 0; n < 40 && !done; n++) begin
         noise = $urandom;
         per_stall = noise[15:0] & ~tmask;
         per_ack   = noise[31:16] & ~tmask;
         if (n >= 2) begin
            if ((n - 1) <= stall_until) per_stall = per_stall | tmask;
            if (ack_at != 0 && (n - 1) >= ack_at) per_ack = per_ack | tmask;
         end
         #4;
         if (cpu_wait) waits++;
         else done = 1;
         if (per_sel != 16'h0000) begin
            sel_cyc++;
            sel_or = sel_or | per_sel;
         end
         if (per_re) begin re_n++; s_addr = per_addr; end
         if (per_we) begin we_n++; s_addr = per_addr; s_wdata = per_wdata; end
         if (done) begin
            rd = cpu_rdata;
            cpu_re = 0; cpu_we = 0;
         end
         step();
      end
      per_stall = '0; per_ack = '0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL access_budget: cpu_wait still high after 40 cycles, addr 0x%0h", addr);
         cpu_re = 0; cpu_we = 0;
      end
   endtask

   initial begin
      int waits, sel_cyc, re_n, we_n, strobes;
      logic [15:0] sel_or;
      logic [7:0]  s_addr, s_wdata, rd;
      logic [7:0]  rd_m;
      logic        ev_m;
      logic [3:0]  es_m;

      vecs[0] = '{1'b0, 1'b1, 12'h010, 8'h00, 0, 0,  3, -1, 16'h0001, 1, 0, 8'hA5};
      vecs[1] = '{1'b1, 1'b0, 12'h321, 8'h3C, 4, 0,  6,  5, 16'h0008, 0, 1, 8'hA5};
      vecs[2] = '{1'b0, 1'b1, 12'h507, 8'h00, 1, 3,  6,  5, 16'h0020, 1, 0, 8'h5A};
      vecs[3] = '{1'b0, 1'b1, 12'hA00, 8'h00, 0, 0,  1,  0, 16'h0000, 0, 0, 8'h00};
      vecs[4] = '{1'b1, 1'b1, 12'h1FE, 8'hC3, 0, 0,  3, -1, 16'h0002, 0, 1, 8'h00};
      vecs[5] = '{1'b0, 1'b1, 12'h2AA, 8'h00, 0, 0,  3, -1, 16'h0004, 1, 0, 8'h22};
      vecs[6] = '{1'b1, 1'b0, 12'hB55, 8'h77, 0, 0,  1,  0, 16'h0000, 0, 0, 8'h22};
      vecs[7] = '{1'b0, 1'b1, 12'h333, 8'h00, 1, 0,  3,  2, 16'h0008, 1, 0, 8'h33};
      vecs[8] = '{1'b0, 1'b1, 12'h500, 8'h00, 8, 0, 10,  9, 16'h0020, 1, 0, 8'h5A};
      vecs[9] = '{1'b0, 1'b1, 12'h401, 8'h00, 0, 0, 10,  9, 16'h0010, 1, 0, 8'hFF};

      rst_n = 0; cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      per_rdata = '0; per_stall = '0; per_ack = '0; err_clr = 0;
      set_slot(0, 8'hA5); set_slot(1, 8'h11); set_slot(2, 8'h22);
      set_slot(3, 8'h33); set_slot(4, 8'h44); set_slot(5, 8'h5A);

      #12;
      chk("rst_per_sel", 32'(per_sel), 32'h0);
      chk("rst_strobes", {30'd0, per_re, per_we}, 32'h0);
      chk("rst_per_addr", 32'(per_addr), 32'h0);
      chk("rst_per_wdata", 32'(per_wdata), 32'h0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'h0);
      chk("rst_cpu_wait", 32'(cpu_wait), 32'h0);
      chk("rst_err", {27'd0, err_valid, err_slot}, 32'h0);
      @(posedge system_clk); #1;
      rst_n = 1;
      step();

      foreach (vecs[i]) begin
         run_access(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].ack_at,
                    vecs[i].stall_until, waits, sel_cyc, sel_or, re_n, we_n, s_addr, s_wdata, rd);
         chk($sformatf("vec%0d_waits", i), 32'(waits), 32'(vecs[i].exp_waits));
         chk($sformatf("vec%0d_sel", i), 32'(sel_or), 32'(vecs[i].exp_sel));
         chk($sformatf("vec%0d_re", i), 32'(re_n), 32'(vecs[i].exp_re));
         chk($sformatf("vec%0d_we", i), 32'(we_n), 32'(vecs[i].exp_we));
         chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
         if (vecs[i].exp_sel_cyc >= 0)
            chk($sformatf("vec%0d_sel_cycles", i), 32'(sel_cyc), 32'(vecs[i].exp_sel_cyc));
         if (re_n + we_n > 0)
            chk($sformatf("vec%0d_per_addr", i), 32'(s_addr), 32'(vecs[i].addr[7:0]));
         if (we_n > 0)
            chk($sformatf("vec%0d_per_wdata", i), 32'(s_wdata), 32'(vecs[i].wdata));
      end

      chk("to1_err_valid", 32'(err_valid), 32'h1);
      chk("to1_err_slot", 32'(err_slot), 32'h4);

      run_access(1'b0, 1'b1, 12'h3F0, 8'h00, 0, 0, waits, sel_cyc, sel_or, re_n, we_n,
                 s_addr, s_wdata, rd);
      chk("to2_waits", 32'(waits), 32'(TO + 2));
      chk("to2_rdata", 32'(rd), 32'hFF);
      chk("to2_err_valid", 32'(err_valid), 32'h1);
      chk("to2_err_slot_kept", 32'(err_slot), 32'h4);

      err_clr = 1; step(); err_clr = 0;
      chk("err_clr", 32'(err_valid), 32'h0);

      // reset in the middle of a slot-3 handshake access
      cpu_addr = 12'h310; cpu_re = 1;
      repeat (3) step();
      chk("mid_sel", 32'(per_sel), 32'h0008);
      chk("mid_wait", 32'(cpu_wait), 32'h1);
      rst_n = 0; cpu_re = 0;
      #1;
      chk("midrst_sel", 32'(per_sel), 32'h0);
      chk("midrst_wait", 32'(cpu_wait), 32'h0);
      chk("midrst_rdata", 32'(cpu_rdata), 32'h0);
      step();
      rst_n = 1;
      strobes = 0;
      for (int c = 0; c < 4; c++) begin
         #4;
         if (per_re || per_we || per_sel != 16'h0000) strobes++;
         step();
      end
      chk("post_rst_no_strobe", 32'(strobes), 32'h0);
      run_access(1'b0, 1'b1, 12'h310, 8'h00, 2, 0, waits, sel_cyc, sel_or, re_n, we_n,
                 s_addr, s_wdata, rd);
      chk("post_rst_waits", 32'(waits), 32'h4);
      chk("post_rst_rdata", 32'(rd), 32'h33);

      // randomized accesses against a cycle-count / data model
      rd_m = 8'h33; ev_m = 0; es_m = 0;
      for (int it = 0; it < 60; it++) begin
         int slot, op, ack_at, st, exp_w, k;
         logic [7:0] rg, wd;
         logic is_wr;
         slot   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 5);
         op     = $urandom_range(0, 2);
         ack_at = $urandom_range(0, 10);
         st     = $urandom_range(0, 4);
         rg     = 8'($urandom);
         wd     = 8'($urandom);
         is_wr  = (op != 0);
         per_rdata = {$urandom, $urandom, $urandom, $urandom};
         if ($urandom_range(0, 5) == 0) begin
            err_clr = 1; step(); err_clr = 0;
            ev_m = 0;
         end
         if (!PRES_M[slot]) begin
            exp_w = 1;
            if (!is_wr) rd_m = 8'h00;
         end else if (!HS_M[slot]) begin
            exp_w = 3;
            if (!is_wr) rd_m = per_rdata[8*slot +: 8];
         end else begin
            k = (ack_at == 0) ? TO + 1 : ((ack_at > st) ? ack_at : st + 1);
            if (k <= TO) begin
               exp_w = k + 2;
               if (!is_wr) rd_m = per_rdata[8*slot +: 8];
            end else begin
               exp_w = TO + 2;
               if (!is_wr) rd_m = 8'hFF;
               if (!ev_m) begin ev_m = 1; es_m = 4'(slot); end
            end
         end
         run_access(op != 0, op != 1, {4'(slot), rg}, wd, ack_at, st, waits, sel_cyc, sel_or,
                    re_n, we_n, s_addr, s_wdata, rd);
         chk($sformatf("rnd%0d_waits", it), 32'(waits), 32'(exp_w));
         chk($sformatf("rnd%0d_rdata", it), 32'(rd), 32'(rd_m));
         chk($sformatf("rnd%0d_re", it), 32'(re_n), 32'(PRES_M[slot] && !is_wr));
         chk($sformatf("rnd%0d_we", it), 32'(we_n), 32'(PRES_M[slot] && is_wr));
         chk($sformatf("rnd%0d_sel", it), 32'(sel_or), PRES_M[slot] ? 32'(16'h0001 << slot) : 32'h0);
         if (re_n + we_n > 0) chk($sformatf("rnd%0d_addr", it), 32'(s_addr), 32'(rg));
         if (we_n > 0) chk($sformatf("rnd%0d_wdata", it), 32'(s_wdata), 32'(wd));
         chk($sformatf("rnd%0d_err_valid", it), 32'(err_valid), 32'(ev_m));
         if (ev_m) chk($sformatf("rnd%0d_err_slot", it), 32'(err_slot), 32'(es_m));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mmio_access_ctrl.md
# mmio_access_ctrl

Bus-access sequencer between the AVR core's data-space I/O window and the 16 memory-mapped peripheral slots, each slot 256 registers. Each CPU read or write goes through one state machine. The sequencer decodes the slot from address bits [11:8] and drives a per-slot select with one-cycle strobes. It holds the CPU in wait until the access completes: a fixed one-cycle turnaround for legacy slots, or a peripheral ack for handshake slots such as vgaterm, ps2 and sd. A watchdog aborts hung handshakes and records the failing slot.

## Interface
- `PRESENT`, default 16'h003F: slots that are populated. An access to an unpopulated slot completes with no strobe.
- `HS_MASK`, default 16'h0038: slots that use the stall/ack handshake. All other populated slots are legacy.
- `TIMEOUT`, default 8'd255: maximum number of WAIT cycles for a handshake slot before the access is aborted.
- `system_clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_re`  in  1  CPU read request. Held high until `cpu_wait` falls.
- `cpu_we`  in  1  CPU write request. Same rule as `cpu_re`.
- `cpu_addr`  in  12  register address; [11:8] is the slot, [7:0] is the register.
- `cpu_wdata`  in  8  write data.
- `cpu_rdata`  out  8  read data, registered.
- `cpu_wait`  out  1  stall to the CPU.
- `per_sel`  out  16  one-hot slot select.
- `per_re`  out  1  read strobe.
- `per_we`  out  1  write strobe.
- `per_addr`  out  8  register address within the slot.
- `per_wdata`  out  8  write data to the peripheral.
- `per_rdata`  in  128  read data, flat; slot n is [8n+7:8n].
- `per_stall`  in  16  per-slot stall.
- `per_ack`  in  16  per-slot completion ack.
- `err_valid`  out  1  sticky timeout flag.
- `err_slot`  out  4  slot number of the first timeout.
- `err_clr`  in  1  synchronous clear for `err_valid`.

## Operation
- **States:** IDLE, ISSUE, WAIT, DONE.
- **IDLE, request accepted:** when `cpu_re` or `cpu_we` is high, latch slot, register, wdata and op, then go to ISSUE.
  - If `cpu_re` and `cpu_we` are both high, the access is a write.
- **IDLE, unpopulated slot:** go straight to DONE; a read returns 8'h00.
- **ISSUE (1 cycle):** assert `per_sel[slot]`; assert `per_re` or `per_we` for this one cycle only; go to WAIT.
- **WAIT, legacy slot:** one cycle. Sample `per_rdata[slot]` into `cpu_rdata` on the closing edge (read only), then go to DONE.
- **WAIT, handshake slot:**
  - `per_sel[slot]` stays high; strobes stay low.
  - `per_stall[slot]` high: wait.
  - `per_ack[slot]` high and stall low: sample rdata (read), go to DONE.
  - Ack is ignored while stall is high.
- **Watchdog:** a counter is cleared in ISSUE and increments every WAIT cycle.
  - When it reaches `TIMEOUT` and no ack arrives in that cycle, go to DONE. A read returns 8'hFF; a write is dropped.
  - If `err_valid` is low, set it and load `err_slot`. If `err_valid` is already high, keep the earlier slot.
- **DONE (1 cycle):** `cpu_wait` low, `per_sel` zero, then go to IDLE. A request seen in the following IDLE is a new access.
- **`cpu_wait`:** combinational; equals (IDLE & (`cpu_re` | `cpu_we`)) | ISSUE | WAIT.
- **`cpu_rdata`:** changes only on read completion; it holds its value across writes.
- **Error flag:** `err_clr` clears `err_valid` and has priority over a timeout set in the same cycle.
- **Outputs:** `per_addr` and `per_wdata` are driven from the latched copies for the whole access.

## Timing
- **Reset values:** state IDLE; `per_sel`=0, `per_re`=0, `per_we`=0, `per_addr`=0, `per_wdata`=0; `cpu_rdata`=0, `err_valid`=0, `err_slot`=0. Watchdog counter is 0.
- **Reset mid-access:** abort the access immediately; no strobe is re-issued after release.
- **Legacy access:** request in cycle T0, strobe in T1, sample in T2, `cpu_wait` low in T3; 3 stall cycles.
- **Handshake access:** with ack in WAIT cycle k (k≥1), `cpu_wait` low in cycle T1+k+1.
- **Worst case:** `TIMEOUT`+2 stall cycles.
- **Unpopulated slot:** `cpu_wait` is high in T0 only; DONE in T1.
- **Counter width:** 8 bits; it never wraps, because reaching `TIMEOUT` exits WAIT.

## Structure
- **Shared package `mmio_pkg`:** state encoding, slot-number constants (BASIC_IO=0, KEYPAD=1, SOUND=2, VGATERM=3, PS2=4, SD=5), and the default `PRESENT`/`HS_MASK` values.
- **Sub-module `mmio_watchdog`:** the counter plus the sticky error register.
- **Integration:** the slot read mux is an indexed part-select of `per_rdata` inside the top module.

## Test plan
- Legacy read of slot 0, reg 0x10, `per_rdata[7:0]`=8'hA5 → a single `per_re` pulse with `per_sel`=16'h0001, `cpu_rdata`=8'hA5, `cpu_wait` high for exactly 3 cycles.
- Write 8'h3C to 0x321, ack after 4 WAIT cycles → `per_we` high 1 cycle, `per_sel`=16'h0008 held 5 cycles, `per_wdata`=8'h3C, `cpu_wait` low at T6.
- Read of slot 5 with stall=1 and ack=1 for 3 cycles, then ack alone → no completion until stall drops; `cpu_rdata` equals slot-5 data.
- Read of slot 4 with no ack, `TIMEOUT`=8 → completes after 8 WAIT cycles, `cpu_rdata`=8'hFF, `err_valid`=1, `err_slot`=4. A second timeout on slot 3 leaves `err_slot`=4. `err_clr` clears the flag.
- Read of 0xA00 (unpopulated) → no strobes, `cpu_rdata`=8'h00, one stall cycle. Then `cpu_re` and `cpu_we` both high → a write is performed.
- `rst_n` low during WAIT of a slot-3 access → `per_sel`=0, `cpu_wait`=0, state IDLE; a subsequent read completes normally.
